// File: rtl/weight_row_loader.sv
// weight_row_loader: packs a stream of weight elements into rows and writes them to the weight RAM
module weight_row_loader #(
    parameter int NROW          = 16,
    parameter int NCOL          = 16,
    parameter int BITWIDTH      = 18,
    parameter int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [BITWIDTH-1:0]      dataIn,
    input  logic                     dataValid,
    output logic                     dataReady,
    output logic [ADDR_BITWIDTH-1:0] addressIn,
    output logic [BITWIDTH*NROW-1:0] rowIn,
    output logic                     writeEn,
    output logic                     busy,
    output logic                     done
);
    localparam int ELEM_BITWIDTH = (NROW > 1) ? $clog2(NROW) : 1;
    localparam logic [ELEM_BITWIDTH-1:0] LAST_ELEM = ELEM_BITWIDTH'(NROW - 1);
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ROW  = ADDR_BITWIDTH'(NCOL - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                   state, state_next;
    logic [ELEM_BITWIDTH-1:0] elem_cnt, elem_cnt_next;
    logic [ADDR_BITWIDTH-1:0] row_cnt, row_cnt_next;
    logic [BITWIDTH-1:0]      slot [NROW];
    logic                     transfer;
    logic                     last_elem;
    logic                     last_row;

    assign transfer  = (state == FILL) && dataValid;
    assign last_elem = elem_cnt == LAST_ELEM;
    assign last_row  = row_cnt == LAST_ROW;

    // FSM state and element/row counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            elem_cnt <= '0;
            row_cnt  <= '0;
        end else begin
            state    <= state_next;
            elem_cnt <= elem_cnt_next;
            row_cnt  <= row_cnt_next;
        end
    end

    // next-state and counter updates; the row address only advances when leaving WRITE
    always_comb begin
        state_next    = state;
        elem_cnt_next = elem_cnt;
        row_cnt_next  = row_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = FILL;
                    elem_cnt_next = '0;
                    row_cnt_next  = '0;
                end
            end
            FILL: begin
                if (transfer) begin
                    state_next    = last_elem ? WRITE : FILL;
                    elem_cnt_next = last_elem ? '0 : elem_cnt + ELEM_BITWIDTH'(1);
                end
            end
            WRITE: begin
                state_next   = last_row ? DONE : FILL;
                row_cnt_next = last_row ? row_cnt : row_cnt + ADDR_BITWIDTH'(1);
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // assembly buffer; every slot is rewritten before the next row write, so it is never cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NROW; k++) slot[k] <= '0;
        end else if (transfer) begin
            slot[elem_cnt] <= dataIn;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NROW; i++) begin : g_row
            assign rowIn[i*BITWIDTH +: BITWIDTH] = slot[i];
        end
    endgenerate

    assign dataReady = state == FILL;
    assign writeEn   = state == WRITE;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign addressIn = row_cnt;
endmodule

// File: tb/tb_weight_row_loader.sv
// tb_weight_row_loader: scoreboard bench for weight_row_loader, small 4x2 and default 16x16 instances
module tb_weight_row_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int t0 [2];

    logic         s_start = 1'b0, s_valid = 1'b0;
    logic [17:0]  s_data = '0;
    logic         s_rdy, s_we, s_busy, s_done;
    logic [0:0]   s_addr;
    logic [71:0]  s_row;

    logic         b_start = 1'b0, b_valid = 1'b0;
    logic [17:0]  b_data = '0;
    logic         b_rdy, b_we, b_busy, b_done;
    logic [3:0]   b_addr;
    logic [287:0] b_row;

    weight_row_loader #(.NROW(4), .NCOL(2), .BITWIDTH(18)) dut_s (
        .clk(clk), .reset(rst_n), .start(s_start), .dataIn(s_data), .dataValid(s_valid),
        .dataReady(s_rdy), .addressIn(s_addr), .rowIn(s_row), .writeEn(s_we),
        .busy(s_busy), .done(s_done)
    );

    weight_row_loader dut_b (
        .clk(clk), .reset(rst_n), .start(b_start), .dataIn(b_data), .dataValid(b_valid),
        .dataReady(b_rdy), .addressIn(b_addr), .rowIn(b_row), .writeEn(b_we),
        .busy(b_busy), .done(b_done)
    );

    typedef struct {
        bit           dn;
        int           c;
        int           a;
        logic [287:0] r;
    } ev_t;

    ev_t q_s [$];
    ev_t q_b [$];

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [287:0] row_of(input int base, input int n);
        logic [287:0] r = '0;
        for (int k = 0; k < n; k++) r[k*18 +: 18] = 18'(base + k);
        return r;
    endfunction

    task automatic push(input bit big, input bit dn, input int c, input int a, input logic [287:0] r);
        ev_t e;
        e.dn = dn;
        e.c  = c;
        e.a  = a;
        e.r  = r;
        if (big) q_b.push_back(e);
        else q_s.push_back(e);
    endtask

    task automatic check_ev(input string tag, input ev_t e, input bit dn, input int c, input int a,
                            input logic [287:0] r, input bit bsy);
        chk({tag, "_kind"}, 288'(dn), 288'(e.dn));
        if (e.c >= 0) chk({tag, "_cycle"}, 288'(c), 288'(e.c));
        if (!e.dn) begin
            chk({tag, "_addr"}, 288'(a), 288'(e.a));
            chk({tag, "_row"}, r, e.r);
        end else begin
            chk({tag, "_done_busy"}, 288'(bsy), 288'(1));
        end
    endtask

    // monitor: every write strobe or done pulse must match the head of the instance's queue
    always @(negedge clk) begin
        if (s_we || s_done) begin
            if (q_s.size() == 0) chk("small_unexpected_event", 288'({s_we, s_done}), 288'(0));
            else check_ev("small", q_s.pop_front(), s_done, cyc - t0[0], int'(s_addr), 288'(s_row), s_busy);
        end
        if (b_we || b_done) begin
            if (q_b.size() == 0) chk("big_unexpected_event", 288'({b_we, b_done}), 288'(0));
            else check_ev("big", q_b.pop_front(), b_done, cyc - t0[1], int'(b_addr), b_row, b_busy);
        end
    end

    task automatic go(input bit big);
        if (big) b_start = 1'b1;
        else s_start = 1'b1;
        t0[big] = cyc;
        tick;
        b_start = 1'b0;
        s_start = 1'b0;
    endtask

    task automatic send(input bit big, input logic [17:0] d, input logic [17:0] junk);
        bit acc;
        int n = 0;
        do begin
            acc = big ? b_rdy : s_rdy;
            if (big) begin
                b_valid = 1'b1;
                b_data  = acc ? d : junk;
            end else begin
                s_valid = 1'b1;
                s_data  = acc ? d : junk;
            end
            tick;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_accepted", 288'(acc), 288'(1));
    endtask

    task automatic chk_zero(input bit big, input string tag);
        chk({tag, "_ready"}, 288'(big ? b_rdy : s_rdy), 288'(0));
        chk({tag, "_we"}, 288'(big ? b_we : s_we), 288'(0));
        chk({tag, "_busy"}, 288'(big ? b_busy : s_busy), 288'(0));
        chk({tag, "_done"}, 288'(big ? b_done : s_done), 288'(0));
        chk({tag, "_addr"}, big ? 288'(b_addr) : 288'(s_addr), 288'(0));
        chk({tag, "_row"}, big ? b_row : 288'(s_row), 288'(0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #1;
        chk_zero(0, "rst_small");
        chk_zero(1, "rst_big");
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // in order, dataValid held high
        push(0, 0, 5, 0, row_of(1, 4));
        push(0, 0, 10, 1, row_of(5, 4));
        push(0, 1, 11, -1, '0);
        go(0);
        chk("t1_busy", 288'(s_busy), 288'(1));
        chk("t1_ready", 288'(s_rdy), 288'(1));
        for (int i = 1; i <= 8; i++) send(0, 18'(i), 18'(i));
        s_valid = 1'b0;
        tick;
        tick;
        chk("t1_idle_busy", 288'(s_busy), 288'(0));
        chk("t1_idle_ready", 288'(s_rdy), 288'(0));

        // gaps 1,0,0 with start pulses mid-row
        push(0, 0, -1, 0, row_of(11, 4));
        push(0, 0, -1, 1, row_of(15, 4));
        push(0, 1, -1, -1, '0);
        go(0);
        for (int i = 0; i < 8; i++) begin
            send(0, 18'(11 + i), 18'h3FFFF);
            s_valid = 1'b0;
            s_data  = 18'h3FFFF;
            tick;
            tick;
            if (i == 1 || i == 5) begin
                s_start = 1'b1;
                tick;
                s_start = 1'b0;
                chk("t2_start_ignored_addr", 288'(s_addr), 288'(i == 5));
                chk("t2_start_ignored_busy", 288'(s_busy), 288'(1));
            end
        end
        tick;
        tick;
        tick;
        chk("t2_idle_busy", 288'(s_busy), 288'(0));

        // all-ones junk offered in WRITE and DONE must not be consumed
        push(0, 0, 5, 0, row_of(21, 4));
        push(0, 0, 10, 1, row_of(25, 4));
        push(0, 1, 11, -1, '0);
        go(0);
        for (int i = 21; i <= 28; i++) send(0, 18'(i), 18'h3FFFF);
        s_data = 18'h3FFFF;
        tick;
        tick;
        tick;
        s_valid = 1'b0;
        tick;

        // reset after 2 of 4 elements of row 1, then a fresh load
        push(0, 0, 5, 0, row_of(31, 4));
        go(0);
        for (int i = 31; i <= 36; i++) send(0, 18'(i), 18'(i));
        s_valid = 1'b0;
        chk("t4_ready_before_reset", 288'(s_rdy), 288'(1));
        #2 rst_n = 1'b0;
        #1;
        chk_zero(0, "t4_async");
        chk("t4_no_pending_writes", 288'(q_s.size()), 288'(0));
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        push(0, 0, 5, 0, row_of(41, 4));
        push(0, 0, 10, 1, row_of(45, 4));
        push(0, 1, 11, -1, '0);
        go(0);
        chk("t4_restart_addr", 288'(s_addr), 288'(0));
        for (int i = 41; i <= 48; i++) send(0, 18'(i), 18'(i));
        s_valid = 1'b0;
        tick;
        tick;
        chk("t4_idle_busy", 288'(s_busy), 288'(0));

        // full 16x16 matrix, then a second one started the cycle after done
        for (int r = 0; r < 16; r++) push(1, 0, 17 * (r + 1), r, row_of(16 * r, 16));
        push(1, 1, 273, -1, '0);
        go(1);
        for (int i = 0; i < 256; i++) send(1, 18'(i), 18'(i));
        b_valid = 1'b0;
        n = 0;
        while (cyc - t0[1] < 274 && n < 400) begin
            tick;
            n++;
        end
        chk("t5_idle_before_restart", 288'(b_busy), 288'(0));
        for (int r = 0; r < 16; r++) push(1, 0, 17 * (r + 1), r, row_of(18'h20000 + 16 * r, 16));
        push(1, 1, 273, -1, '0);
        go(1);
        chk("t5_restart_addr", 288'(b_addr), 288'(0));
        chk("t5_restart_busy", 288'(b_busy), 288'(1));
        for (int i = 0; i < 256; i++) send(1, 18'(18'h20000 + i), 18'(18'h20000 + i));
        b_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        chk("t5_final_busy", 288'(b_busy), 288'(0));

        chk("small_queue_drained", 288'(q_s.size()), 288'(0));
        chk("big_queue_drained", 288'(q_b.size()), 288'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/weight_row_loader.md
# weight_row_loader

Write-side companion of the weight RAM: accepts a stream of BITWIDTH-bit weight elements over a valid/ready handshake and packs NROW consecutive elements into one row. Each completed row is written to the weight RAM through its `addressIn`/`rowIn`/`writeEn` port, with addresses 0 to NCOL-1 in order. It is used to load initial or retrained weight matrices into the network before inference.

## Interface
- NROW, 16, elements per row; also the number of row slots in the RAM word.
- NCOL, 16, rows per matrix; also the RAM depth.
- BITWIDTH, 18, bits per weight element (fixed-point, passed through unmodified).
- ADDR_BITWIDTH, log2(NCOL), derived; the address width.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begins loading a full matrix; sampled only in IDLE.
- dataIn  input  BITWIDTH  weight element.
- dataValid  input  1  dataIn is valid.
- dataReady  output  1  loader accepts an element this cycle.
- addressIn  output  ADDR_BITWIDTH  RAM row address for the write.
- rowIn  output  BITWIDTH*NROW  packed row to write.
- writeEn  output  1  RAM write strobe, exactly one clk cycle per row.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last row is written.

## Operation
- FSM states: IDLE, FILL, WRITE, DONE. All outputs decode from registers only, with no combinational input-to-output path.
- IDLE: dataReady=0, writeEn=0, busy=0. If start=1, go to FILL and set elemCnt=0 and rowCnt=0.
- FILL: dataReady=1. A transfer occurs when dataValid and dataReady are both 1.
  - On a transfer, dataIn is stored in slot elemCnt, i.e. rowIn[elemCnt*BITWIDTH +: BITWIDTH]. The first element of a row lands in the LSB slot.
  - elemCnt increments on each transfer. The transfer at elemCnt==NROW-1 moves the FSM to WRITE and resets elemCnt to 0.
  - dataValid=0 stalls FILL indefinitely, with no timeout.
- WRITE: writeEn=1, dataReady=0, addressIn=rowCnt, rowIn holds the completed row.
  - If rowCnt==NCOL-1, go to DONE.
  - Otherwise increment rowCnt and go to FILL.
- DONE: done=1 for one cycle, then go to IDLE.
- The assembly buffer drives rowIn directly.
  - It is not cleared between rows, because every slot is overwritten before the next write.
  - rowIn content outside WRITE is don't-care, since writeEn=0.
- addressIn equals rowCnt at all times. It changes only on the exit from WRITE and never wraps mid-matrix.
- start while busy is ignored. dataValid outside FILL is ignored, and no element is consumed.
- Reset values while reset=0, applied asynchronously:
  - state=IDLE, elemCnt=0, rowCnt=0, buffer=0.
  - dataReady=0, writeEn=0, busy=0, done=0, addressIn=0, rowIn=0.
- Reset mid-operation aborts the load. No partial row is written, and rows already written stay in the RAM.
- After reset is released, the loader waits in IDLE for a new start.

## Timing
- The RAM samples writeEn, addressIn and rowIn on the falling clk edge. All loader outputs change only on rising edges, so they are stable half a cycle before the RAM samples them.
- start is sampled in cycle 0, and FILL is entered in cycle 1.
- With dataValid held high, each row takes NROW transfer cycles plus 1 WRITE cycle.
- Row r is written in cycle (r+1)*(NROW+1).
- done is high in cycle NCOL*(NROW+1)+1. With the defaults this is cycle 273.
- busy stays high from cycle 1 through the DONE cycle inclusive.
- dataReady falls in the cycle after the NROW-th transfer of a row and returns high in the cycle after WRITE. This leaves a one-cycle bubble per row.
- Throughput: one element per cycle within a row.

## Test plan
- Order and addressing: NROW=4, NCOL=2, start, then elements 1..8 with dataValid held high.
  - writeEn in cycle 5 with addressIn=0 and rowIn slots {4,3,2,1} (MSB to LSB).
  - writeEn in cycle 10 with addressIn=1 and slots {8,7,6,5}.
  - done in cycle 11, then IDLE with busy=0.
- Backpressure and gaps: same configuration, dataValid toggled 1,0,0,1,...
  - No element is dropped or duplicated, and the same two rows are written.
  - writeEn is asserted only twice, each time for a single cycle.
- Ignored inputs:
  - start pulsed during FILL: no restart, and rowCnt is unchanged.
  - dataValid=1 with dataIn=18'h3FFFF in the WRITE and DONE cycles: not consumed, so the next row's slot 0 still holds the next valid element.
- Reset mid-row: reset=0 after 2 of 4 elements of row 1.
  - All outputs go to 0 immediately (asynchronously), with no writeEn.
  - A subsequent start reloads from addressIn=0.
- Full default size (16x16), elements 0..255 streamed continuously.
  - 16 writes at cycles 17, 34, ..., 272.
  - Row r slot k equals 16r+k.
  - done in cycle 273.
- Back-to-back matrices: start in the cycle after done. The second load begins normally and addressIn restarts at 0.
